// File: rtl/wb_spi_slave_pkg.sv
// Shared constants for the Wishbone SPI responder: register offsets,
// STATUS/CTRL bit positions and shift-engine state encodings.
package wb_spi_slave_pkg;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_RX_VALID = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_OVF   = 2;
  localparam int ST_TX_OVF   = 3;
  localparam int ST_BUSY     = 4;
  localparam int ST_SELECTED = 5;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_RX_IE  = 1;
  localparam int CTRL_TX_IE  = 2;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 responder shift engine: synchronizes the pad inputs into clk,
// detects SCLK/SS edges, shifts RX/TX bytes MSB first and drives MISO.
module spi_slave_shifter
  import wb_spi_slave_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       spi_sclk,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       tx_load_req,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       selected,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  // [0]/[1] are the synchronizer stages, [2] is the history bit for edge detect
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] ss_sync_q,   ss_sync_d;
  logic [2:0] mosi_sync_q, mosi_sync_d;

  logic [0:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       oe_q, oe_d;

  logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_bit;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  // MOSI is stable for several clk cycles around SCLK rise, so the older sample is safe
  assign mosi_bit  = mosi_sync_q[2];

  assign busy        = (bit_cnt_q != 4'd0);
  assign selected    = ~ss_sync_q[1];
  assign spi_miso_oe = oe_q;
  assign spi_miso    = oe_q ? tx_shift_q[7] : 1'b1;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
    ss_sync_d   = {ss_sync_q[1:0], spi_ss_n};
    mosi_sync_d = {mosi_sync_q[1:0], spi_mosi};

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    oe_d        = oe_q;
    tx_load_req = 1'b0;
    byte_done   = 1'b0;
    rx_byte     = {rx_shift_q[6:0], mosi_bit};

    case (state_q)
      IDLE: begin
        if (enable && ss_fall) begin
          state_d     = SHIFT;
          bit_cnt_d   = 4'd0;
          oe_d        = 1'b1;
          tx_shift_d  = tx_byte;
          tx_load_req = 1'b1;
        end
      end
      SHIFT: begin
        if (!enable || ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = 4'd0;
          oe_d      = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          byte_done  = (bit_cnt_q == 4'd7);
        end else if (sclk_fall) begin
          // The falling edge after bit 8 starts the next byte within the same select
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d   = 4'd0;
            tx_shift_d  = tx_byte;
            tx_load_req = 1'b1;
          end else if (bit_cnt_q != 4'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= 3'b000;
      ss_sync_q   <= 3'b111;
      mosi_sync_q <= 3'b000;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      rx_shift_q  <= 8'd0;
      tx_shift_q  <= 8'd0;
      oe_q        <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      oe_q        <= oe_d;
    end
  end

endmodule

// File: rtl/wb_spi_slave.sv
// Wishbone register wrapper for the SPI responder: RXDATA/TXDATA/STATUS/CTRL
// registers, overflow tracking and the level interrupt.
module wb_spi_slave
  import wb_spi_slave_pkg::*;
#(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_empty_q, tx_empty_d;
  logic        rx_ovf_q, rx_ovf_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        intr_q, intr_d;

  logic        tx_load_req, byte_done, busy, selected;
  logic [7:0]  rx_byte, tx_byte;
  logic [1:0]  reg_sel;
  logic        bus_rd, bus_wr;
  logic        unused_bits;

  assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i};
  assign reg_sel     = wb_adr_i[3:2];
  assign tx_byte     = tx_empty_q ? DEFAULT_TX : tx_hold_q;

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr     = intr_q;

  spi_slave_shifter u_shifter (
    .clk         (clk),
    .reset       (reset),
    .enable      (ctrl_q[CTRL_ENABLE]),
    .spi_sclk    (spi_sclk),
    .spi_ss_n    (spi_ss_n),
    .spi_mosi    (spi_mosi),
    .tx_byte     (tx_byte),
    .tx_load_req (tx_load_req),
    .byte_done   (byte_done),
    .rx_byte     (rx_byte),
    .busy        (busy),
    .selected    (selected),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe)
  );

  always_comb begin
    ack_d  = wb_stb_i & wb_cyc_i & ~ack_q;
    bus_rd = ack_d & ~wb_we_i;
    bus_wr = ack_d & wb_we_i;

    dat_d = 32'd0;
    if (bus_rd) begin
      case (reg_sel)
        REG_RXDATA: dat_d[7:0] = rx_data_q;
        REG_STATUS: begin
          dat_d[ST_RX_VALID] = rx_valid_q;
          dat_d[ST_TX_EMPTY] = tx_empty_q;
          dat_d[ST_RX_OVF]   = rx_ovf_q;
          dat_d[ST_TX_OVF]   = tx_ovf_q;
          dat_d[ST_BUSY]     = busy;
          dat_d[ST_SELECTED] = selected;
        end
        REG_CTRL:   dat_d[2:0] = ctrl_q;
        default:    dat_d = 32'd0;
      endcase
    end

    // RX path: a CPU pop is applied before a byte arriving in the same cycle
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_ovf_d   = rx_ovf_q;
    if (bus_rd && reg_sel == REG_RXDATA) rx_valid_d = 1'b0;
    if (bus_wr && reg_sel == REG_STATUS && wb_dat_i[ST_RX_OVF]) rx_ovf_d = 1'b0;
    if (byte_done) begin
      if (!rx_valid_d) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovf_d = 1'b1;
      end
    end

    // TX path: the shifter load sees pre-write state, then the CPU write lands
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    tx_ovf_d   = tx_ovf_q;
    if (tx_load_req) tx_empty_d = 1'b1;
    if (bus_wr && reg_sel == REG_STATUS && wb_dat_i[ST_TX_OVF]) tx_ovf_d = 1'b0;
    if (bus_wr && reg_sel == REG_TXDATA) begin
      if (tx_empty_d) begin
        tx_hold_d  = wb_dat_i[7:0];
        tx_empty_d = 1'b0;
      end else begin
        tx_ovf_d = 1'b1;
      end
    end

    ctrl_d = ctrl_q;
    if (bus_wr && reg_sel == REG_CTRL) ctrl_d = wb_dat_i[2:0];

    intr_d = ctrl_d[CTRL_ENABLE] &
             ((ctrl_d[CTRL_RX_IE] & (rx_valid_d | rx_ovf_d)) |
              (ctrl_d[CTRL_TX_IE] & tx_empty_d));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      rx_data_q  <= 8'd0;
      tx_hold_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_empty_q <= 1'b1;
      rx_ovf_q   <= 1'b0;
      tx_ovf_q   <= 1'b0;
      ctrl_q     <= 3'd0;
      intr_q     <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      rx_data_q  <= rx_data_d;
      tx_hold_q  <= tx_hold_d;
      rx_valid_q <= rx_valid_d;
      tx_empty_q <= tx_empty_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_ovf_q   <= tx_ovf_d;
      ctrl_q     <= ctrl_d;
      intr_q     <= intr_d;
    end
  end

endmodule

// File: tb/tb_wb_spi_slave.sv
// Bench for wb_spi_slave: directed scenarios plus randomized CPU/SPI traffic
// checked against a register-level behavioural model.
module tb_wb_spi_slave;
  import wb_spi_slave_pkg::*;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o, intr;
  logic        spi_sclk, spi_ss_n, spi_mosi, spi_miso, spi_miso_oe;

  wb_spi_slave #(.DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .intr(intr),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the register file
  logic [7:0] m_rx_data, m_tx_hold;
  logic       m_rx_valid, m_tx_empty, m_rx_ovf, m_tx_ovf;
  logic [2:0] m_ctrl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_rx_data = 8'd0; m_tx_hold = 8'd0; m_rx_valid = 1'b0; m_tx_empty = 1'b1;
    m_rx_ovf = 1'b0; m_tx_ovf = 1'b0; m_ctrl = 3'd0;
  endtask

  function automatic logic [31:0] m_status();
    return {26'd0, 1'b0, 1'b0, m_tx_ovf, m_rx_ovf, m_tx_empty, m_rx_valid};
  endfunction

  function automatic logic m_intr();
    return m_ctrl[0] & ((m_ctrl[1] & (m_rx_valid | m_rx_ovf)) | (m_ctrl[2] & m_tx_empty));
  endfunction

  task automatic m_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      REG_TXDATA: if (m_tx_empty) begin m_tx_hold = d[7:0]; m_tx_empty = 1'b0; end
                  else m_tx_ovf = 1'b1;
      REG_STATUS: begin
        if (d[2]) m_rx_ovf = 1'b0;
        if (d[3]) m_tx_ovf = 1'b0;
      end
      REG_CTRL:   m_ctrl = d[2:0];
      default: ;
    endcase
  endtask

  task automatic m_read(input logic [1:0] a, output logic [31:0] e);
    case (a)
      REG_RXDATA: begin e = {24'd0, m_rx_data}; m_rx_valid = 1'b0; end
      REG_STATUS: e = m_status();
      REG_CTRL:   e = {29'd0, m_ctrl};
      default:    e = 32'd0;
    endcase
  endtask

  // Byte the responder will shift out at each byte boundary
  task automatic m_consume(output logic [7:0] b);
    b = m_tx_empty ? 8'hFF : m_tx_hold;
    m_tx_empty = 1'b1;
  endtask

  task automatic m_rx(input logic [7:0] b);
    if (!m_rx_valid) begin m_rx_data = b; m_rx_valid = 1'b1; end
    else m_rx_ovf = 1'b1;
  endtask

  task automatic wb_cycle(input logic [1:0] a, input logic we, input logic [31:0] d,
                          output logic [31:0] q);
    int n;
    @(posedge clk); #1;
    wb_adr_i = {28'd0, a, 2'b00}; wb_dat_i = d; wb_we_i = we;
    wb_sel_i = 4'hF; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!wb_ack_o && n < 10);
    chk("ack_latency", n, 1);
    q = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", 32'(wb_ack_o), 32'd0);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_cycle(a, 1'b1, d, q);
    m_write(a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, input string tag);
    logic [31:0] q, e;
    m_read(a, e);
    wb_cycle(a, 1'b0, 32'd0, q);
    chk(tag, q, e);
  endtask

  task automatic spi_shift(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      repeat (HALF) @(posedge clk); #1;
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (HALF) @(posedge clk); #1;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_select();
    spi_ss_n = 1'b0;
    repeat (HALF) @(posedge clk); #1;
    chk("miso_oe_sel", 32'(spi_miso_oe), 32'd1);
  endtask

  task automatic spi_deselect();
    repeat (HALF) @(posedge clk); #1;
    spi_ss_n = 1'b1;
    repeat (HALF) @(posedge clk); #1;
    chk("miso_oe_idle", 32'(spi_miso_oe), 32'd0);
    chk("miso_idle", 32'(spi_miso), 32'd1);
  endtask

  task automatic spi_bytes(input int nb, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] mi, e, mo;
    spi_select();
    for (int b = 0; b < nb; b++) begin
      mo = (b == 0) ? d0 : d1;
      m_consume(e);
      spi_shift(mo, 8, mi);
      chk("miso_byte", {24'd0, mi}, {24'd0, e});
      m_rx(mo);
    end
    m_consume(e);
    spi_deselect();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  mi, e;
    logic [31:0] q, es;

    reset = 1'b1; wb_adr_i = 32'd0; wb_dat_i = 32'd0; wb_sel_i = 4'h0;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    m_reset();
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_intr", 32'(intr), 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd1);
    chk("rst_oe", 32'(spi_miso_oe), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 1: idle byte with nothing queued
    bus_read(REG_STATUS, "status_reset");
    bus_write(REG_CTRL, 32'h01);
    bus_read(REG_CTRL, "ctrl_rb");
    spi_bytes(1, 8'hA5, 8'h00);
    bus_read(REG_STATUS, "status_rx1");
    bus_read(REG_RXDATA, "rx_a5");
    bus_read(REG_STATUS, "status_popped");

    // 2: queued TX byte
    bus_write(REG_TXDATA, 32'h3C);
    spi_bytes(1, 8'h81, 8'h00);
    bus_read(REG_STATUS, "status_tx_used");
    bus_read(REG_RXDATA, "rx_81");

    // 3: overrun and W1C
    spi_bytes(1, 8'h11, 8'h00);
    spi_bytes(1, 8'h22, 8'h00);
    bus_read(REG_STATUS, "status_ovf");
    bus_read(REG_RXDATA, "rx_keep_old");
    bus_write(REG_STATUS, 32'h04);
    bus_read(REG_STATUS, "status_w1c");

    // 4: partial byte discarded
    spi_select();
    m_consume(e);
    spi_shift(8'hC3, 5, mi);
    chk("miso_partial", {27'd0, mi[4:0]}, {27'd0, e[7:3]});
    spi_deselect();
    bus_read(REG_STATUS, "status_partial");
    spi_bytes(1, 8'hF0, 8'h00);
    bus_read(REG_RXDATA, "rx_f0");

    // 5: interrupt and TX overflow
    bus_write(REG_CTRL, 32'h07);
    chk("intr_tx_empty", 32'(intr), 32'd1);
    bus_write(REG_TXDATA, 32'hAA);
    chk("intr_tx_full", 32'(intr), 32'd0);
    spi_bytes(1, 8'h42, 8'h00);
    chk("intr_rx", 32'(intr), 32'd1);
    bus_write(REG_TXDATA, 32'h01);
    bus_write(REG_TXDATA, 32'h02);
    bus_read(REG_STATUS, "status_tx_ovf");
    bus_read(REG_RXDATA, "rx_42");
    bus_write(REG_STATUS, 32'h08);

    // 6: reset in the middle of a byte
    spi_select();
    m_consume(e);
    spi_shift(8'h99, 4, mi);
    m_read(REG_STATUS, es);
    wb_cycle(REG_STATUS, 1'b0, 32'd0, q);
    chk("status_busy_sel", q, es | 32'h30);
    reset = 1'b1;
    #2;
    chk("midrst_oe", 32'(spi_miso_oe), 32'd0);
    chk("midrst_miso", 32'(spi_miso), 32'd1);
    chk("midrst_intr", 32'(intr), 32'd0);
    chk("midrst_ack", 32'(wb_ack_o), 32'd0);
    spi_ss_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    repeat (2) @(posedge clk); #1;
    bus_read(REG_STATUS, "status_after_rst");
    bus_write(REG_CTRL, 32'h01);
    spi_bytes(1, 8'h5A, 8'h00);
    bus_read(REG_RXDATA, "rx_5a");

    // Randomized traffic
    bus_write(REG_CTRL, 32'h07);
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: bus_write(REG_TXDATA, $urandom_range(0, 255));
        1: spi_bytes($urandom_range(1, 2), 8'($urandom), 8'($urandom));
        2: bus_read(REG_RXDATA, "rx_rand");
        3: bus_read(REG_STATUS, "status_rand");
        default: bus_write(REG_STATUS, $urandom_range(0, 15));
      endcase
      chk("intr_rand", 32'(intr), 32'(m_intr()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_spi_slave.md
Name: wb_spi_slave

Overview:
Wishbone-slave peripheral that acts as the responder end of an SPI link, complementing the on-chip SPI master. An external SPI master clocks bytes in and out. The CPU reads received bytes and queues transmit bytes through four memory-mapped registers, using polled or interrupt-driven service. The block sits on the conbus as an ordinary slave.

Parameters:
- DEFAULT_TX, 8'hFF: byte shifted out when no TX byte is queued at byte start.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- wb_adr_i, input, 32: byte address. Only [3:2] are decoded.
- wb_dat_i, input, 32: write data. Only [7:0] are used.
- wb_dat_o, output, 32: read data.
- wb_sel_i, input, 4: byte select. Ignored; accesses are 32-bit.
- wb_stb_i, input, 1: strobe.
- wb_cyc_i, input, 1: cycle.
- wb_we_i, input, 1: write enable.
- wb_ack_o, output, 1: acknowledge.
- intr, output, 1: level interrupt, active-high.
- spi_sclk, input, 1: asynchronous SPI clock from the master.
- spi_ss_n, input, 1: asynchronous select, active-low.
- spi_mosi, input, 1: asynchronous master-out data.
- spi_miso, output, 1: slave-out data.
- spi_miso_oe, output, 1: MISO output enable for the pad tristate.

Behaviour:
Reset values:
- wb_ack_o=0, wb_dat_o=0, intr=0, spi_miso=1, spi_miso_oe=0.
- All registers are 0, except STATUS.tx_empty=1.

SPI format and sampling:
- Mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit bytes.
- spi_sclk, spi_ss_n and spi_mosi each pass through a 2-FF synchronizer plus one history FF; edges are detected on clk.
- Required: f_clk >= 8 x f_sclk.

Wishbone handshake:
- wb_ack_o <= stb & cyc & ~wb_ack_o, so ack is high for exactly one cycle and comes 1 cycle after the request.
- Read data is valid while ack is high. Side effects take effect on the ack cycle.

Register map (adr[3:2]):
- 0 RXDATA (R): [7:0]=rx byte. A read clears rx_valid.
- 1 TXDATA (W): loads tx_hold and clears tx_empty. A write while tx_empty=0 is dropped and sets tx_ovf.
- 2 STATUS (R; W1C on [2],[3]):
  - [0] rx_valid
  - [1] tx_empty
  - [2] rx_ovf
  - [3] tx_ovf
  - [4] busy (byte in progress)
  - [5] selected (synchronized ss_n==0)
- 3 CTRL (RW):
  - [0] enable
  - [1] rx_ie
  - [2] tx_ie
- Reads of unused bits and writes to read-only fields: read as 0 / ignored.

Shift engine:
- States: IDLE, SHIFT.
- IDLE -> SHIFT on synchronized ss_n falling while enable=1:
  - bit_cnt=0, spi_miso_oe=1.
  - tx_shift loads tx_hold if tx_empty=0 (then tx_empty<=1), else DEFAULT_TX.
  - spi_miso=tx_shift[7].
- sclk rising: rx_shift <= {rx_shift[6:0], mosi_sync}; bit_cnt++.
- sclk falling with bit_cnt in 1..7: tx_shift shifts left, so spi_miso shows the next bit.
- sclk falling with bit_cnt==8:
  - bit_cnt=0.
  - tx_shift reloads from tx_hold or DEFAULT_TX, exactly as at select.
  - Back-to-back bytes within one select are supported.
- Byte complete (8th rising edge):
  - If rx_valid=0: rx_data <= byte and rx_valid <= 1.
  - Else: rx_ovf <= 1 and the old rx_data is kept.
- busy=1 while bit_cnt != 0.
- SHIFT -> IDLE on ss_n rising, or when enable is cleared:
  - Any partial byte is discarded; bit_cnt=0, spi_miso_oe=0, spi_miso=1.
  - tx_hold is unaffected.

Simultaneous events:
- RXDATA read on the same cycle as byte complete: the pop applies first, then the new byte loads. Result: rx_valid=1, no overrun, the read returns the old byte.
- TXDATA write on the same cycle as a tx_shift load: the load takes the pre-write state, then the write fills tx_hold.
- W1C on the same cycle as a new overflow event: the set wins.

Interrupt:
- intr = enable & ((rx_ie & (rx_valid | rx_ov f)) | (tx_ie & tx_empty)), registered.

Reset mid-transfer:
- Asynchronous return to reset values; the partial byte is lost.

Decomposition:
- Package wb_spi_slave_pkg holds:
  - register offsets REG_RXDATA=0, REG_TXDATA=1, REG_STATUS=2, REG_CTRL=3;
  - STATUS/CTRL bit indices;
  - state encodings IDLE/SHIFT.
- One sub-module, spi_slave_shifter:
  - contains the synchronizers, edge detect, bit counter, shift registers and MISO drive;
  - exposes byte_done/rx_byte and tx_load_req/tx_byte to the register wrapper.

Test Plan:
1. Reset, then read STATUS -> 0x02. Set CTRL=0x01; master sends 0xA5 with no TX queued -> MISO bits read 0xFF, RXDATA=0xA5, rx_valid then clears on read.
2. Write TXDATA=0x3C, then the master transfers 0x81 -> master receives 0x3C, RXDATA=0x81, STATUS.tx_empty=1 after select.
3. Master sends 0x11 then 0x22 with no CPU read -> RXDATA=0x11, rx_ovf=1. Writing STATUS=0x04 clears rx_ovf.
4. Deassert ss_n after 5 bits, then send full byte 0xF0 -> rx_valid only after 0xF0, RXDATA=0xF0, and spi_miso_oe=0 between selects.
5. CTRL=0x07 -> intr=1 immediately (tx_empty). Write TXDATA -> intr=0. Receive a byte -> intr=1. Write TXDATA twice -> tx_ovf=1.
6. Assert reset during bit 4 -> all outputs return to reset values within the reset assertion. The next full byte 0x5A is received correctly.
